mem_access_unit: RTL

Multicycle-datapath memory access unit sitting directly downstream of the control unit. Converts the control unit's per-stage memory controls (instruction fetch or data access, read/write) into a registered request/acknowledge transaction on a single-port, variable-latency memory. Returns a one-cycle `done` pulse that the control unit uses to leave IF/MEM. Holds the instruction register (IR) and memory data register (MDR), with RV32I byte/half/word store lane steering and load extension.

---
 rtl/mem_access_unit.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: IF/MEM request/ack bridge to a variable-latency memory.
// Holds IR and MDR, steers RV32I store lanes and extends loads.
// Ports: clk_i, reset_i (sync, active-high); control-unit side
//   mem_read_i, mem_write_i, data_access_i, inst_reg_write_i,
//   mem_reg_write_i, pc_i, alu_out_i, store_data_i, funct3_i;
//   status busy_o, done_o, fault_o; registers ir_o, mdr_o;
//   memory side mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
//   mem_wstrb_o, mem_ack_i, mem_rdata_i.
// Option: define MEM_TIMEOUT_EN to fault a REQ after TIMEOUT_CYCLES.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic        data_access_i,
  input  logic        inst_reg_write_i,
  input  logic        mem_reg_write_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] alu_out_i,
  input  logic [31:0] store_data_i,
  input  logic [2:0]  funct3_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        fault_o,
  output logic [31:0] ir_o,
  output logic [31:0] mdr_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD
  } state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_e;

  state_e      state_q, state_d;
  size_e       size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] mdr_q, mdr_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST =
    8'(TIMEOUT_CYCLES - 1);
  logic [7:0]  cnt_q, cnt_d;
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = TIMEOUT_CYCLES;
`endif

  logic        req;
  logic [31:0] ea;
  size_e       size_n;
  logic        bad;
  logic [31:0] wdata_n;
  logic [3:0]  wstrb_n;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] ext;

  // Request decode against the live control inputs.
  always_comb begin
    req = mem_read_i | mem_write_i;
    ea  = data_access_i ? alu_out_i : pc_i;
    size_n = SZ_W;
    if (data_access_i) begin
      unique case (funct3_i[1:0])
        2'd0:    size_n = SZ_B;
        2'd1:    size_n = SZ_H;
        default: size_n = SZ_W;
      endcase
    end
    bad = (mem_read_i & mem_write_i)
        | ((size_n == SZ_W) && (ea[1:0] != 2'd0))
        | ((size_n == SZ_H) && ea[0]);
    unique case (size_n)
      SZ_B: begin
        wstrb_n = 4'b0001 << ea[1:0];
        wdata_n = {4{store_data_i[7:0]}};
      end
      SZ_H: begin
        wstrb_n = 4'b0011 << ea[1:0];
        wdata_n = {2{store_data_i[15:0]}};
      end
      default: begin
        wstrb_n = 4'b1111;
        wdata_n = store_data_i;
      end
    endcase
    if (!mem_write_i) wstrb_n = 4'b0000;
  end

  // Load lane select by the offset latched at accept.
  always_comb begin
    unique case (off_q)
      2'd0: lb = mem_rdata_i[7:0];
      2'd1: lb = mem_rdata_i[15:8];
      2'd2: lb = mem_rdata_i[23:16];
      2'd3: lb = mem_rdata_i[31:24];
    endcase
    lh = off_q[1] ? mem_rdata_i[31:16]
                  : mem_rdata_i[15:0];
    unique case (size_q)
      SZ_B: ext = uns_q ? {24'd0, lb}
                        : {{24{lb[7]}}, lb};
      SZ_H: ext = uns_q ? {16'd0, lh}
                        : {{16{lh[15]}}, lh};
      default: ext = mem_rdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    done_d  = 1'b0;
    fault_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req && bad) begin
          state_d = S_HOLD;
          done_d  = 1'b1;
          fault_d = 1'b1;
        end else if (req) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          we_d    = mem_write_i;
          addr_d  = {ea[31:2], 2'b00};
          wdata_d = wdata_n;
          wstrb_d = wstrb_n;
          size_d  = size_n;
          uns_d   = data_access_i & funct3_i[2];
          off_d   = ea[1:0];
`ifdef MEM_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      S_REQ: begin
        if (mem_ack_i) begin
          state_d = S_HOLD;
          req_d   = 1'b0;
          we_d    = 1'b0;
          wstrb_d = 4'b0000;
          done_d  = 1'b1;
          if (!we_q && inst_reg_write_i)
            ir_d = mem_rdata_i;
          if (!we_q && mem_reg_write_i)
            mdr_d = ext;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          state_d = S_HOLD;
          req_d   = 1'b0;
          we_d    = 1'b0;
          wstrb_d = 4'b0000;
          done_d  = 1'b1;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      S_HOLD: begin
        if (!req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      size_q  <= SZ_W;
      uns_q   <= 1'b0;
      off_q   <= 2'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      ir_q    <= 32'd0;
      mdr_q   <= 32'd0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      done_q  <= done_d;
      fault_q <= fault_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign fault_o     = fault_q;
  assign ir_o        = ir_q;
  assign mdr_o       = mdr_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wstrb_o = wstrb_q;

endmodule
